// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the IMEM boot loader: FSM states, error codes, frame layout.
package boot_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CLR,
    LEN0,
    LEN1,
    DATA,
    WR,
    CSUM,
    RUN,
    ERR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // LEN_LO + LEN_HI bytes ahead of the payload
  localparam int HDR_BYTES = 2;

endpackage

// File: rtl/imem_boot_loader_assembler.sv
// Packs accepted payload bytes into little-endian 32-bit words and keeps the running XOR checksum.
module boot_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic        word_done,
  output logic [31:0] word_nxt,
  output logic [7:0]  csum
);

  logic [1:0]  byte_idx_q;
  logic [31:0] word_q;

  // word_nxt already contains the incoming byte, so the 4th byte's word is usable on the same edge
  always_comb begin
    word_nxt = word_q;
    word_nxt[{byte_idx_q, 3'b000} +: 8] = byte_in;
  end

  assign word_done = accept && (byte_idx_q == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_idx_q <= 2'd0;
      word_q     <= 32'd0;
      csum       <= 8'd0;
    end else if (clear) begin
      byte_idx_q <= 2'd0;
      word_q     <= 32'd0;
      csum       <= 8'd0;
    end else if (accept) begin
      byte_idx_q <= byte_idx_q + 2'd1;
      word_q     <= word_nxt;
      csum       <= csum ^ byte_in;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed byte stream, writes words into IMEM, verifies the
// XOR checksum and then releases the core from reset.
//
// state | meaning
// IDLE  | after reset, core held in reset, waiting for start
// CLR   | one-cycle IMEM reset pulse, clear load bookkeeping
// LEN0  | wait for word-count low byte
// LEN1  | wait for word-count high byte, validate length
// DATA  | collect payload bytes of the current word
// WR    | one-cycle IMEM write of the assembled word
// CSUM  | wait for checksum byte
// RUN   | image loaded, core running
// ERR   | load failed, core held in reset
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_W           = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              core_rst,
  output logic              imem_rst,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_loaded
);

  state_t            state_q, state_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [7:0]        len_lo_q;
  logic [15:0]       len_q;
  logic [15:0]       len_n;
  logic [ADDR_W:0]   word_idx_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_wdata_q;

  logic        xfer;
  logic        to_hit;
  logic        len_bad;
  logic        last_word;
  logic        word_done;
  logic [31:0] word_nxt;
  logic [7:0]  csum;

  assign rx_ready = state_q inside {LEN0, LEN1, DATA, CSUM};
  assign xfer     = rx_valid && rx_ready;

  assign len_n     = {rx_data, len_lo_q};
  assign len_bad   = (len_n == 16'd0) || (32'(len_n) > (32'd1 << ADDR_W));
  assign last_word = (32'(word_idx_q) + 32'd1) == 32'(len_q);
  assign to_hit    = to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1);

  boot_word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (state_q == CLR),
    .accept    (xfer && (state_q == DATA)),
    .byte_in   (rx_data),
    .word_done (word_done),
    .word_nxt  (word_nxt),
    .csum      (csum)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;
    end
  end

  // An accepted byte always takes priority over a timeout in the same cycle
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    unique case (state_q)
      IDLE: if (start) state_d = CLR;
      CLR: begin
        state_d    = LEN0;
        err_code_d = ERR_NONE;
      end
      LEN0: begin
        if (xfer) state_d = LEN1;
        else if (to_hit) begin
          state_d    = ERR;
          err_code_d = ERR_TIMEOUT;
        end
      end
      LEN1: begin
        if (xfer) begin
          if (len_bad) begin
            state_d    = ERR;
            err_code_d = ERR_LEN;
          end else begin
            state_d = DATA;
          end
        end else if (to_hit) begin
          state_d    = ERR;
          err_code_d = ERR_TIMEOUT;
        end
      end
      DATA: begin
        if (xfer) begin
          if (word_done) state_d = WR;
        end else if (to_hit) begin
          state_d    = ERR;
          err_code_d = ERR_TIMEOUT;
        end
      end
      WR: state_d = last_word ? CSUM : DATA;
      CSUM: begin
        if (xfer) begin
          if (rx_data == csum) begin
            state_d = RUN;
          end else begin
            state_d    = ERR;
            err_code_d = ERR_CSUM;
          end
        end else if (to_hit) begin
          state_d    = ERR;
          err_code_d = ERR_TIMEOUT;
        end
      end
      RUN: if (start) state_d = CLR;
      ERR: if (start) state_d = CLR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_lo_q     <= 8'd0;
      len_q        <= 16'd0;
      word_idx_q   <= '0;
      to_cnt_q     <= '0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
    end else begin
      if ((state_q == CLR) || xfer) to_cnt_q <= '0;
      else if (rx_ready)            to_cnt_q <= to_cnt_q + TO_W'(1);

      if ((state_q == LEN0) && xfer) len_lo_q <= rx_data;
      if ((state_q == LEN1) && xfer) len_q    <= len_n;

      if (state_q == CLR)     word_idx_q <= '0;
      else if (state_q == WR) word_idx_q <= word_idx_q + (ADDR_W + 1)'(1);

      // Captured on the 4th byte so address/data are valid throughout WR and held afterwards
      if (word_done) begin
        imem_addr_q  <= word_idx_q[ADDR_W-1:0];
        imem_wdata_q <= word_nxt;
      end
    end
  end

  assign core_rst     = (state_q != RUN);
  assign imem_rst     = (state_q == CLR);
  assign imem_we      = (state_q == WR);
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign busy         = state_q inside {CLR, LEN0, LEN1, DATA, WR, CSUM};
  assign done         = (state_q == RUN);
  assign err          = (state_q == ERR);
  assign err_code     = err_code_q;
  assign words_loaded = word_idx_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized self-checking bench for imem_boot_loader against a frame-level reference model.
module tb_imem_boot_loader;
  import boot_pkg::HDR_BYTES;

  localparam int ADDR_W = 10;
  localparam int TOC    = 16;
  localparam int TO_W   = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        rx_data = 8'd0;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              core_rst;
  logic              imem_rst;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   words_loaded;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int we_count = 0;

  logic [ADDR_W-1:0] exp_addr[$];
  logic [31:0]       exp_data[$];
  logic [7:0]        acc_log[$];
  logic [7:0]        sent[$];
  logic [31:0]       frame_words[$];

  imem_boot_loader #(
    .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TOC), .TO_W(TO_W)
  ) dut (
    .clk(clk), .rst(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .core_rst(core_rst), .imem_rst(imem_rst), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] xor_words();
    logic [7:0] x = 8'd0;
    foreach (frame_words[i]) x = x ^ frame_words[i][7:0] ^ frame_words[i][15:8]
                                   ^ frame_words[i][23:16] ^ frame_words[i][31:24];
    return x;
  endfunction

  function automatic int lat_of(input int n);
    return 1 + HDR_BYTES + 5 * n + 1;
  endfunction

  function automatic int gap_of(input bit hold);
    return hold ? 0 : int'($urandom_range(0, 3));
  endfunction

  // Per-cycle compare against the expected write queue and output invariants
  always @(negedge clk) begin
    if (rst_n) begin
      chk("core_rst_vs_done", 64'(core_rst), 64'(!done));
      if (rx_valid && rx_ready) acc_log.push_back(rx_data);
      if (imem_we) begin
        we_count++;
        chk("ready_low_in_wr", 64'(rx_ready), 64'(0));
        chk("write_expected", 64'(exp_addr.size() != 0), 64'(1));
        if (exp_addr.size() != 0) begin
          chk("wr_addr", 64'(imem_addr), 64'(exp_addr.pop_front()));
          chk("wr_data", 64'(imem_wdata), 64'(exp_data.pop_front()));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 1'b0;
    for (int g = 0; g < gap; g++) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    sent.push_back(b);
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    chk("byte_accepted_in_time", 64'(ok), 64'(1));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
    chk("clr_imem_rst", 64'(imem_rst), 64'(1));
    chk("clr_core_rst", 64'(core_rst), 64'(1));
    chk("clr_busy", 64'(busy), 64'(1));
    chk("clr_done_err", 64'({done, err}), 64'(0));
    @(posedge clk); #1;
    chk("imem_rst_one_cycle", 64'(imem_rst), 64'(0));
    chk("clr_err_code", 64'(err_code), 64'(0));
    chk("clr_words_loaded", 64'(words_loaded), 64'(0));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_core_rst"}, 64'(core_rst), 64'(1));
    chk({tag, "_flags"}, 64'({done, err, busy, rx_ready, imem_we, imem_rst}), 64'(0));
    chk({tag, "_err_code"}, 64'(err_code), 64'(0));
    chk({tag, "_words"}, 64'(words_loaded), 64'(0));
    chk({tag, "_addr"}, 64'(imem_addr), 64'(0));
    chk({tag, "_wdata"}, 64'(imem_wdata), 64'(0));
  endtask

  task automatic run_frame(input int n, input bit bad, input bit hold);
    logic [7:0] cs;
    bit         valid;
    int         we0;
    int         mism;
    valid = (n != 0) && (n <= (1 << ADDR_W));
    cs    = xor_words();
    if (bad) cs = cs ^ 8'($urandom_range(1, 255));
    acc_log.delete();
    sent.delete();
    exp_addr.delete();
    exp_data.delete();
    we0 = we_count;
    if (valid) begin
      foreach (frame_words[i]) begin
        exp_addr.push_back(ADDR_W'(i));
        exp_data.push_back(frame_words[i]);
      end
    end
    pulse_start();
    send_byte(8'(n), gap_of(hold));
    send_byte(8'(n >> 8), gap_of(hold));
    if (valid) begin
      foreach (frame_words[i])
        for (int k = 0; k < 4; k++) send_byte(frame_words[i][8*k +: 8], gap_of(hold));
      send_byte(cs, gap_of(hold));
    end
    rx_valid = 1'b0;
    if (valid) begin
      if (hold) chk("load_latency", 64'(cyc - t0), 64'(lat_of(n)));
      chk("final_done", 64'(done), 64'(!bad));
      chk("final_err", 64'(err), 64'(bad));
      chk("final_err_code", 64'(err_code), 64'(bad ? 2 : 0));
      chk("final_words", 64'(words_loaded), 64'(n));
      chk("final_core_rst", 64'(core_rst), 64'(bad));
      chk("write_count", 64'(we_count - we0), 64'(n));
    end else begin
      chk("badlen_err", 64'(err), 64'(1));
      chk("badlen_done", 64'(done), 64'(0));
      chk("badlen_err_code", 64'(err_code), 64'(1));
      chk("badlen_words", 64'(words_loaded), 64'(0));
      chk("badlen_no_write", 64'(we_count), 64'(we0));
    end
    chk("writes_outstanding", 64'(exp_addr.size()), 64'(0));
    chk("accepted_count", 64'(acc_log.size()), 64'(sent.size()));
    mism = 0;
    foreach (sent[i]) if (i >= acc_log.size() || acc_log[i] !== sent[i]) mism++;
    chk("accepted_order", 64'(mism), 64'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int we0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Pin the reference model with hand-computed values
    frame_words = '{32'h12345678, 32'hDEADBEEF};
    chk("model_xor", 64'(xor_words()), 64'h2A);
    chk("model_latency", 64'(lat_of(2)), 64'd14);

    // Good frame, continuous rx_valid
    run_frame(2, 1'b0, 1'b1);
    // Same frame, wrong checksum, random gaps
    run_frame(2, 1'b1, 1'b0);
    // Bad lengths: zero and one past IMEM size
    run_frame(0, 1'b0, 1'b1);
    run_frame(1025, 1'b0, 1'b0);

    // Stall after 3 payload bytes until the timeout fires
    frame_words = '{32'hCAFEF00D};
    exp_addr.delete();
    exp_data.delete();
    we0 = we_count;
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    for (int b = 0; b < 3; b++) send_byte(frame_words[0][8*b +: 8], 0);
    rx_valid = 1'b0;
    k = 0;
    while (!err && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("timeout_cycles", 64'(k), 64'(TOC));
    chk("timeout_err_code", 64'(err_code), 64'(3));
    chk("timeout_no_write", 64'(we_count), 64'(we0));
    chk("timeout_core_rst", 64'(core_rst), 64'(1));

    // Random frames with random gaps and occasional bad checksums
    for (int f = 0; f < 8; f++) begin
      int n;
      n = int'($urandom_range(1, 8));
      frame_words.delete();
      for (int i = 0; i < n; i++) frame_words.push_back($urandom);
      run_frame(n, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
    end

    // Largest image the address space allows
    frame_words.delete();
    for (int i = 0; i < (1 << ADDR_W); i++) frame_words.push_back($urandom);
    run_frame(1 << ADDR_W, 1'b0, 1'b1);

    // Async reset in the middle of the second word
    frame_words = '{32'hA5A55A5A, 32'h0BADC0DE};
    exp_addr.delete();
    exp_data.delete();
    exp_addr.push_back(ADDR_W'(0));
    exp_data.push_back(frame_words[0]);
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int b = 0; b < 4; b++) send_byte(frame_words[0][8*b +: 8], 0);
    for (int b = 0; b < 2; b++) send_byte(frame_words[1][8*b +: 8], 0);
    chk("pre_reset_busy", 64'(busy), 64'(1));
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    rx_valid = 1'b0;
    chk("mid_reset_first_word_written", 64'(exp_addr.size()), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Load from IDLE, then reload from RUN
    run_frame(2, 1'b0, 1'b0);
    frame_words = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
    run_frame(3, 1'b0, 1'b1);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
